// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: bundle widths,
// control/payload field offsets and the stage occupancy state.
package pipe_pkg;

    // Control bundle {RegWrite, MemtoReg, MemWrite, Branch, ALUControl[3:0], ALUSrc, ALUSrc_shamt, RegDst}
    localparam int PIPE_CTRL_W       = 11;
    localparam int ALU_CTRL_W        = 4;
    localparam int CTRL_REGWRITE     = 10;
    localparam int CTRL_MEMTOREG     = 9;
    localparam int CTRL_MEMWRITE     = 8;
    localparam int CTRL_BRANCH       = 7;
    localparam int CTRL_ALUCTRL_LSB  = 3;
    localparam int CTRL_ALUSRC       = 2;
    localparam int CTRL_ALUSRC_SHAMT = 1;
    localparam int CTRL_REGDST       = 0;

    // Payload {RD1, RD2, SignImm, PCplus4, Rt, Rd, shamt}
    localparam int PIPE_DATA_W      = 143;
    localparam int DATA_RD1_LSB     = 111;
    localparam int DATA_RD2_LSB     = 79;
    localparam int DATA_SIGNIMM_LSB = 47;
    localparam int DATA_PCPLUS4_LSB = 15;
    localparam int DATA_RT_LSB      = 10;
    localparam int DATA_RD_LSB      = 5;
    localparam int DATA_SHAMT_LSB   = 0;

    localparam int PIPE_CNT_W = 16;

    // Occupancy of a two-entry elastic stage
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/id_ex_elastic_if.sv
// Valid/ready stream carrying one decoded instruction (control + payload).
interface id_ex_elastic_if #(
    parameter int CTRL_W = 11,
    parameter int DATA_W = 143
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/id_ex_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;

    // Count requested cycles, stopping at the maximum value
    always_ff @(posedge CLOCK) begin
        if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
endmodule

// File: rtl/id_ex_elastic.sv
// Elastic ID/EX stage: main register drives EX, skid register absorbs the
// one instruction that may arrive while EX stalls, so nothing is lost.
module id_ex_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic                CLOCK,
    input  logic                RESET,
    id_ex_elastic_if.slave      in_bus,
    id_ex_elastic_if.master     out_bus,
    input  logic                flush,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt
);
    stage_state_e      state_r;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic [1:0]        occupancy_r;

    logic accept_s;
    logic release_s;
    logic stall_s;

    // in_ready is a register, so accept never depends combinationally on out_ready
    assign accept_s  = in_bus.valid & in_ready_r;
    assign release_s = out_valid_r & out_bus.ready;
    assign stall_s   = out_valid_r & ~out_bus.ready;

    // Occupancy FSM and datapath; main_ctrl is zeroed whenever the stage empties
    // so a bubble never carries live control bits into EX
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r     <= EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else if (flush) begin
            // Any release this cycle already completed; any accept is dropped
            state_r     <= EMPTY;
            main_ctrl_r <= {CTRL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ONE;
                        main_ctrl_r <= in_bus.ctrl;
                        main_data_r <= in_bus.data;
                        out_valid_r <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && release_s) begin
                        main_ctrl_r <= in_bus.ctrl;
                        main_data_r <= in_bus.data;
                    end else if (accept_s) begin
                        state_r     <= FULL;
                        skid_ctrl_r <= in_bus.ctrl;
                        skid_data_r <= in_bus.data;
                        in_ready_r  <= 1'b0;
                        occupancy_r <= 2'd2;
                    end else if (release_s) begin
                        state_r     <= EMPTY;
                        main_ctrl_r <= {CTRL_W{1'b0}};
                        out_valid_r <= 1'b0;
                        occupancy_r <= 2'd0;
                    end else begin
                        state_r <= ONE;
                    end
                end
                FULL: begin
                    if (release_s) begin
                        state_r     <= ONE;
                        main_ctrl_r <= skid_ctrl_r;
                        main_data_r <= skid_data_r;
                        in_ready_r  <= 1'b1;
                        occupancy_r <= 2'd1;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    main_ctrl_r <= {CTRL_W{1'b0}};
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    occupancy_r <= 2'd0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLOCK (CLOCK),
        .clr   (RESET),
        .inc   (stall_s),
        .count (stall_cnt)
    );

    assign in_bus.ready  = in_ready_r;
    assign out_bus.valid = out_valid_r;
    assign out_bus.ctrl  = main_ctrl_r;
    assign out_bus.data  = main_data_r;
    assign occupancy     = occupancy_r;
endmodule

// File: tb/tb_id_ex_elastic.sv
// Bench for id_ex_elastic: directed vector table, hand sequences for
// saturation / empty behaviour, then random traffic against a queue model.
module tb_id_ex_elastic;
    localparam int CW = 11;
    localparam int DW = 143;

    logic          CLOCK;
    logic          RESET;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;
    logic [1:0]    occ_a, occ_b;
    logic [15:0]   stall_a;
    logic [3:0]    stall_b;

    id_ex_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) in_a ();
    id_ex_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) out_a ();
    id_ex_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) in_b ();
    id_ex_elastic_if #(.CTRL_W(CW), .DATA_W(DW)) out_b ();

    assign in_a.valid  = in_valid;
    assign in_a.ctrl   = in_ctrl;
    assign in_a.data   = in_data;
    assign out_a.ready = out_ready;
    assign in_b.valid  = in_valid;
    assign in_b.ctrl   = in_ctrl;
    assign in_b.data   = in_data;
    assign out_b.ready = out_ready;

    id_ex_elastic dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_bus(in_a), .out_bus(out_a),
        .flush(flush), .occupancy(occ_a), .stall_cnt(stall_a)
    );

    id_ex_elastic #(.CNT_W(4)) dut4 (
        .CLOCK(CLOCK), .RESET(RESET), .in_bus(in_b), .out_bus(out_b),
        .flush(flush), .occupancy(occ_b), .stall_cnt(stall_b)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: FIFO of held instructions, capacity two
    typedef struct {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } instr_t;

    instr_t        m_q[$];
    logic [DW-1:0] m_last;
    int            m_s16;
    int            m_s4;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_update(logic v, logic [CW-1:0] c, logic [DW-1:0] d,
                                         logic r, logic f, logic rst);
        bit can_take;
        bit took;
        bit gave;
        if (rst) begin
            m_q.delete();
            m_last = '0;
            m_s16  = 0;
            m_s4   = 0;
        end else begin
            can_take = (m_q.size() < 2);
            took     = v && can_take;
            gave     = (m_q.size() > 0) && r;
            if ((m_q.size() > 0) && !r) begin
                if (m_s16 < 65535) m_s16++;
                if (m_s4 < 15) m_s4++;
            end
            if (gave) void'(m_q.pop_front());
            if (f) m_q.delete();
            else if (took) m_q.push_back('{ctrl: c, data: d});
            if (m_q.size() > 0) m_last = m_q[0].data;
        end
    endfunction

    function automatic void compare_model();
        bit            ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        ev = (m_q.size() > 0);
        ec = ev ? m_q[0].ctrl : '0;
        ed = ev ? m_q[0].data : m_last;
        check("model in_ready",  DW'(in_a.ready),  DW'(m_q.size() < 2));
        check("model out_valid", DW'(out_a.valid), DW'(ev));
        check("model out_ctrl",  DW'(out_a.ctrl),  DW'(ec));
        check("model out_data",  out_a.data,       ed);
        check("model occupancy", DW'(occ_a),       DW'(m_q.size()));
        check("model stall16",   DW'(stall_a),     DW'(m_s16));
        check("model stall4",    DW'(stall_b),     DW'(m_s4));
    endfunction

    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic r, input logic f, input logic rst);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = r;
        flush     = f;
        RESET     = rst;
        @(posedge CLOCK);
        model_update(v, c, d, r, f, rst);
        #1;
        compare_model();
    endtask

    // Directed vector: inputs for one edge and the outputs expected after it
    typedef struct {
        logic          v;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        logic          r;
        logic          f;
        logic          rst;
        logic          ev;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed;
        logic [1:0]    eo;
        logic          er;
        int            es;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [159:0] rnd;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0; RESET = 1'b1;

        //              v     c       d        r     f     rst   ev    ec      ed       eo    er    es
        // reset
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000, 143'h0,  2'd0, 1'b1, 0});
        // back-to-back stream with EX ready
        tbl.push_back('{1'b1, 11'h7FF, 143'h1, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 143'h1,  2'd1, 1'b1, 0});
        tbl.push_back('{1'b1, 11'h7FF, 143'h2, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 143'h2,  2'd1, 1'b1, 0});
        tbl.push_back('{1'b1, 11'h7FF, 143'h3, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 143'h3,  2'd1, 1'b1, 0});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 143'h3,  2'd0, 1'b1, 0});
        // back-pressure: A then B fill the stage, then drain in order
        tbl.push_back('{1'b1, 11'h123, 143'hA, 1'b0, 1'b0, 1'b0, 1'b1, 11'h123, 143'hA,  2'd1, 1'b1, 0});
        tbl.push_back('{1'b1, 11'h456, 143'hB, 1'b0, 1'b0, 1'b0, 1'b1, 11'h123, 143'hA,  2'd2, 1'b0, 1});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h123, 143'hA,  2'd2, 1'b0, 2});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h456, 143'hB,  2'd1, 1'b1, 2});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 143'hB,  2'd0, 1'b1, 2});
        // flush while FULL with an offer pending: offer never appears
        tbl.push_back('{1'b1, 11'h111, 143'hC, 1'b0, 1'b0, 1'b0, 1'b1, 11'h111, 143'hC,  2'd1, 1'b1, 2});
        tbl.push_back('{1'b1, 11'h222, 143'hD, 1'b0, 1'b0, 1'b0, 1'b1, 11'h111, 143'hC,  2'd2, 1'b0, 3});
        tbl.push_back('{1'b1, 11'h333, 143'hE, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000, 143'hC,  2'd0, 1'b1, 4});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 143'hC,  2'd0, 1'b1, 4});
        // reset together with flush while FULL, then resume
        tbl.push_back('{1'b1, 11'h0AA, 143'hF, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0AA, 143'hF,  2'd1, 1'b1, 4});
        tbl.push_back('{1'b1, 11'h055, 143'h10, 1'b0, 1'b0, 1'b0, 1'b1, 11'h0AA, 143'hF, 2'd2, 1'b0, 5});
        tbl.push_back('{1'b1, 11'h3C3, 143'h99, 1'b0, 1'b1, 1'b1, 1'b0, 11'h000, 143'h0, 2'd0, 1'b1, 0});
        tbl.push_back('{1'b1, 11'h7FF, 143'h11, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 143'h11, 2'd1, 1'b1, 0});
        tbl.push_back('{1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 143'h11, 2'd0, 1'b1, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].r, tbl[i].f, tbl[i].rst);
            check($sformatf("vec%0d out_valid", i), DW'(out_a.valid), DW'(tbl[i].ev));
            check($sformatf("vec%0d out_ctrl", i),  DW'(out_a.ctrl),  DW'(tbl[i].ec));
            check($sformatf("vec%0d out_data", i),  out_a.data,       tbl[i].ed);
            check($sformatf("vec%0d occupancy", i), DW'(occ_a),       DW'(tbl[i].eo));
            check($sformatf("vec%0d in_ready", i),  DW'(in_a.ready),  DW'(tbl[i].er));
            check($sformatf("vec%0d stall16", i),   DW'(stall_a),     DW'(tbl[i].es));
            check($sformatf("vec%0d stall4", i),    DW'(stall_b),     DW'(tbl[i].es));
        end

        // Empty stage with EX ready: nothing emerges for 10 cycles
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 11'h7FF, 143'h55, 1'b1, 1'b0, 1'b0);
            check("empty out_valid", DW'(out_a.valid), DW'(1'b0));
            check("empty out_ctrl",  DW'(out_a.ctrl),  DW'(11'h000));
        end

        // Stall counter saturation, kept across flush, cleared by reset
        step(1'b0, 11'h000, 143'h0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 11'h0F0, 143'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 11'h000, 143'h0, 1'b0, 1'b0, 1'b0);
        check("sat stall4 at 15",  DW'(stall_b), DW'(4'd15));
        check("sat stall16 at 20", DW'(stall_a), DW'(16'd20));
        step(1'b0, 11'h000, 143'h0, 1'b0, 1'b1, 1'b0);
        check("sat stall4 after flush", DW'(stall_b), DW'(4'd15));
        step(1'b0, 11'h000, 143'h0, 1'b1, 1'b0, 1'b0);
        check("sat stall4 held empty", DW'(stall_b), DW'(4'd15));
        step(1'b0, 11'h000, 143'h0, 1'b0, 1'b0, 1'b1);
        check("sat stall4 after reset",  DW'(stall_b), DW'(4'd0));
        check("sat stall16 after reset", DW'(stall_a), DW'(16'd0));

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 3) != 0, CW'($urandom()), rnd[DW-1:0],
                 $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 127) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/id_ex_elastic.md
# id_ex_elastic

Parametrised, elastic successor to the fixed ID/EX pipeline register. It carries one decoded instruction (control bundle plus operand payload) from ID to EX, using a valid/ready handshake and a 2-entry skid buffer, so EX back-pressure never drops or duplicates an instruction. It adds a synchronous flush for branch/hazard squash and a saturating stall counter for performance debug. It sits between the decoder/register file and the ALU stage of the pipelined CPU.

## Interface
Parameters:
- CTRL_W, 11, control bundle width {RegWrite, MemtoReg, MemWrite, Branch, ALUControl[3:0], ALUSrc, ALUSrc_shamt, RegDst}
- DATA_W, 143, payload width {RD1, RD2, SignImm, PCplus4 (4x32), Rt, Rd, shamt (3x5)}
- CNT_W, 16, stall counter width

Ports:
- CLOCK  in  1  clock; all state updates on posedge
- RESET  in  1  reset, synchronous, active-high
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  stage can accept; registered, equals (state != FULL)
- in_ctrl  in  CTRL_W  control bundle from ID
- in_data  in  DATA_W  payload from ID
- flush  in  1  squash all held instructions
- out_valid  out  1  EX-side instruction present
- out_ready  in  1  EX consumes this cycle
- out_ctrl  out  CTRL_W  control to EX; forced 0 when out_valid=0 (bubble)
- out_data  out  DATA_W  payload to EX; holds last value when out_valid=0
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- Storage is a main register (drives out_*) and a skid register.
- States:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main <= in.
  - ONE:
    - accept & release -> ONE, main <= in.
    - accept & !release -> FULL, skid <= in.
    - !accept & release -> EMPTY.
    - else hold.
  - FULL: release -> ONE, main <= skid. No accept is possible (in_ready=0).
- Flush has priority over everything:
  - Next state is EMPTY.
  - Any same-cycle accept is discarded.
  - The EX-side release in the flush cycle still completes, since EX saw it.
- Bubble: whenever out_valid=0, out_ctrl=0, so no RegWrite/MemWrite/Branch leaks into EX.
- stall_cnt increments each cycle where out_valid & !out_ready. It saturates at 2^CNT_W-1 and is not cleared by flush.
- Ordering is strict FIFO: main is always older than skid.

## Timing
- Latency: in_* accepted at edge N appears on out_* after edge N (visible in cycle N+1) when the stage was EMPTY, or ONE with release.
- Throughput: 1 instruction/cycle with out_ready held high.
- in_ready depends only on state, with no combinational path from out_ready.
- Reset values:
  - state EMPTY, occupancy 0.
  - out_valid 0, out_ctrl 0, out_data 0.
  - in_ready 1.
  - stall_cnt 0.
  - skid contents 0.
- Reset mid-operation discards both entries, identical to flush, and additionally clears stall_cnt and out_data.
- flush and RESET together: RESET behaviour.
- Boundary cases:
  - FULL with out_ready=0 holds indefinitely with in_ready=0.
  - EMPTY with out_ready=1 produces nothing.

## Structure
- Shared package pipe_pkg:
  - CTRL_W and field offsets of the control bundle.
  - ALU control width (4).
  - Payload field offsets.
  - State enum {EMPTY, ONE, FULL}.
- The same package is reused by the IF/ID, EX/MEM and MEM/WB elastic stages.
- One natural sub-module, sat_counter (parameter CNT_W, inputs inc/clr), used for stall_cnt.
- The datapath and state machine stay in id_ex_elastic.

## Test plan
- Reset, then stream in_ctrl=11'h7FF with in_data=1,2,3 back-to-back, out_ready=1 -> out_valid from cycle 2, out_data 1,2,3 in consecutive cycles, occupancy 1, stall_cnt 0.
- Hold out_ready=0 and offer A then B -> occupancy 2, in_ready=0 in the cycle after B; raise out_ready -> A then B emitted in order; stall_cnt equals the stalled cycles.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy 0, in_ready=1; the offered instruction never appears.
- Empty pipe, out_ready=1, in_valid=0 -> out_ctrl stays 0 and out_valid stays 0 for 10 cycles.
- CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15; then flush -> stall_cnt still 15; RESET -> 0.
- Assert RESET while FULL with flush=1 -> all outputs at reset values next cycle; the stream then resumes normally.
